// File: rtl/voice_scheduler.sv
// voice_scheduler
//   Time-shares one voice engine across NUM_VOICES voices per sample frame.
//   On a frame tick the enable mask is latched, then each index is scanned in
//   turn. Enabled voices are requested from the engine, and the acked samples
//   are summed. At the end of the frame, a one-cycle mix_valid strobe presents
//   the mixed result.
//
//   Optional feature: define VOICE_SCHED_SATURATE_EN to clip the mix to the
//   signed SAMPLE_WIDTH range. Otherwise the mix wraps (low SAMPLE_WIDTH bits).
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   sample_tick     frame-start strobe
//   voice_enable    per-voice enable mask (latched at frame start)
//   voice_req/idx   request to the shared engine and requested voice index
//   voice_ack       engine acknowledge; voice_sample valid in the same cycle
//   voice_sample    signed engine output
//   mix_out         signed mix of the last completed frame
//   mix_valid       one-cycle strobe marking a new mix_out
//   busy            high whenever the scheduler is not idle
//   overrun         one-cycle pulse when a frame tick was dropped
//   overrun_count   saturating count of dropped ticks
module voice_scheduler #(
    parameter int NUM_VOICES   = 8,
    parameter int SAMPLE_WIDTH = 24
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           sample_tick,
    input  logic [NUM_VOICES-1:0]          voice_enable,
    output logic                           voice_req,
    output logic [$clog2(NUM_VOICES)-1:0]  voice_idx,
    input  logic                           voice_ack,
    input  logic signed [SAMPLE_WIDTH-1:0] voice_sample,
    output logic signed [SAMPLE_WIDTH-1:0] mix_out,
    output logic                           mix_valid,
    output logic                           busy,
    output logic                           overrun,
    output logic [15:0]                    overrun_count
);

    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam int ACC_W = SAMPLE_WIDTH + IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_REQ, S_DONE} state_t;

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [NUM_VOICES-1:0]     mask_q, mask_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [SAMPLE_WIDTH-1:0] mix_q, mix_d;
    logic                      ovr_q, ovr_d;
    logic [15:0]               ovr_cnt_q, ovr_cnt_d;

    logic signed [ACC_W-1:0]   sample_ext;
    logic signed [ACC_W-1:0]   acc_sum;

`ifdef VOICE_SCHED_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(IDX_W + 1){1'b0}}, {(SAMPLE_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(IDX_W + 1){1'b1}}, {(SAMPLE_WIDTH - 1){1'b0}}};
`endif

    // Narrow the frame accumulator to the output sample width.
    function automatic logic signed [SAMPLE_WIDTH-1:0] reduce_acc(input logic signed [ACC_W-1:0] a);
`ifdef VOICE_SCHED_SATURATE_EN
        logic signed [ACC_W-1:0] c;
        if (a > SAT_MAX)
            c = SAT_MAX;
        else if (a < SAT_MIN)
            c = SAT_MIN;
        else
            c = a;
        return c[SAMPLE_WIDTH-1:0];
`else
        return a[SAMPLE_WIDTH-1:0];
`endif
    endfunction

    assign sample_ext = {{IDX_W{voice_sample[SAMPLE_WIDTH-1]}}, voice_sample};
    assign acc_sum    = acc_q + sample_ext;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            mask_q    <= '0;
            acc_q     <= '0;
            mix_q     <= '0;
            ovr_q     <= 1'b0;
            ovr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            mask_q    <= mask_d;
            acc_q     <= acc_d;
            mix_q     <= mix_d;
            ovr_q     <= ovr_d;
            ovr_cnt_q <= ovr_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        mask_d    = mask_q;
        acc_d     = acc_q;
        mix_d     = mix_q;
        ovr_d     = 1'b0;
        ovr_cnt_d = ovr_cnt_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                // DONE accepts a coincident tick directly, so back-to-back
                // frames never pass through IDLE.
                if (sample_tick) begin
                    mask_d  = voice_enable;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = S_SCAN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SCAN: begin
                if (mask_q[idx_q]) begin
                    state_d = S_REQ;
                end else if (idx_q == LAST_IDX) begin
                    mix_d   = reduce_acc(acc_q);
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_REQ: begin
                if (voice_ack) begin
                    acc_d = acc_sum;
                    if (idx_q == LAST_IDX) begin
                        // Load the mix from the post-add sum so it is valid in DONE.
                        mix_d   = reduce_acc(acc_sum);
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_SCAN;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A tick while a frame is in flight is dropped; the frame continues.
        if (sample_tick && (state_q == S_SCAN || state_q == S_REQ)) begin
            ovr_d = 1'b1;
            if (ovr_cnt_q != 16'hFFFF)
                ovr_cnt_d = ovr_cnt_q + 16'd1;
        end
    end

    // Outputs
    always_comb begin
        voice_req     = (state_q == S_REQ);
        voice_idx     = idx_q;
        mix_valid     = (state_q == S_DONE);
        busy          = (state_q != S_IDLE);
        mix_out       = mix_q;
        overrun       = ovr_q;
        overrun_count = ovr_cnt_q;
    end

endmodule

// File: tb/tb_voice_scheduler.sv
`timescale 1ns/1ps
module tb_voice_scheduler;

    localparam int NV = 8;
    localparam int SW = 24;
    localparam int IW = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           sample_tick = 1'b0;
    logic [NV-1:0]  voice_enable = '0;
    logic           voice_req;
    logic [IW-1:0]  voice_idx;
    logic           voice_ack = 1'b0;
    logic [SW-1:0]  voice_sample = '0;
    logic [SW-1:0]  mix_out;
    logic           mix_valid;
    logic           busy;
    logic           overrun;
    logic [15:0]    overrun_count;

    voice_scheduler #(.NUM_VOICES(NV), .SAMPLE_WIDTH(SW)) dut (
        .clk           (clk),
        .rst           (rst),
        .sample_tick   (sample_tick),
        .voice_enable  (voice_enable),
        .voice_req     (voice_req),
        .voice_idx     (voice_idx),
        .voice_ack     (voice_ack),
        .voice_sample  (voice_sample),
        .mix_out       (mix_out),
        .mix_valid     (mix_valid),
        .busy          (busy),
        .overrun       (overrun),
        .overrun_count (overrun_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        logic [SW-1:0] val;
    } mix_exp_t;

    mix_exp_t      mix_q[$];
    int            idx_q[$];
    int            ovr_cyc_q[$];
    int            ovr_cnt_q[$];

    int            n_checks = 0;
    int            n_fail = 0;

    logic [SW-1:0] cur_s[NV];
    logic [SW-1:0] nxt_s[NV];
    int            cur_d[NV];
    int            nxt_d[NV];
    int            start_cyc = 0;
    int            done_cyc = 0;
    int            prev_done = 0;
    int            ovr_model = 0;
    logic [SW-1:0] last_mix = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name, input logic [63:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got %0h (cycle %0d)", name, act, cyc);
    endtask

    // Reference mix: exact integer sum of the enabled voices, then clipped or wrapped.
    function automatic logic [SW-1:0] ref_mix(input longint s);
        longint maxv;
        longint minv;
        longint r;
        maxv = (longint'(1) <<< (SW - 1)) - 1;
        minv = -(longint'(1) <<< (SW - 1));
        r = s;
`ifdef VOICE_SCHED_SATURATE_EN
        if (r > maxv) r = maxv;
        if (r < minv) r = minv;
`else
        if (r > maxv || r < minv) r = r;
`endif
        return SW'(r);
    endfunction

    // Issue a one-cycle tick now; the model decides whether it starts a frame or is dropped.
    task automatic do_tick(input logic [NV-1:0] en);
        int       c;
        longint   s;
        int       lat;
        mix_exp_t e;
        c = cyc;
        if (c < done_cyc) begin
            if (ovr_model < 65535) ovr_model++;
            ovr_cyc_q.push_back(c + 1);
            ovr_cnt_q.push_back(ovr_model);
        end else begin
            s = 0;
            lat = 0;
            for (int i = 0; i < NV; i++) begin
                cur_s[i] = nxt_s[i];
                cur_d[i] = nxt_d[i];
                if (en[i]) begin
                    s += longint'($signed(nxt_s[i]));
                    lat += 1 + nxt_d[i];
                    idx_q.push_back(i);
                end
            end
            prev_done = done_cyc;
            start_cyc = c;
            done_cyc  = c + 1 + NV + lat;
            e.cyc = done_cyc;
            e.val = ref_mix(s);
            mix_q.push_back(e);
        end
        sample_tick  = 1'b1;
        voice_enable = en;
        @(posedge clk); #1;
        sample_tick  = 1'b0;
        voice_enable = NV'($urandom);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((mix_q.size() != 0 || cyc <= done_cyc) && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 300) fail_now("drain_timeout", mix_q.size());
    endtask

    task automatic rand_voices(input int maxd);
        for (int i = 0; i < NV; i++) begin
            nxt_s[i] = SW'($urandom);
            nxt_d[i] = $urandom_range(0, maxd);
        end
    endtask

    // Engine model: acks after the per-voice delay chosen at tick time, and
    // throws stray acks when no request is pending.
    initial begin : engine
        int  e_wait;
        int  e_idx;
        bit  e_in;
        e_in = 0;
        e_wait = 0;
        e_idx = 0;
        forever begin
            @(negedge clk);
            voice_ack    = 1'b0;
            voice_sample = SW'($urandom);
            if (rst) begin
                e_in = 0;
            end else if (voice_req) begin
                if (!e_in) begin
                    e_in   = 1;
                    e_idx  = int'(voice_idx);
                    e_wait = cur_d[e_idx];
                    if (idx_q.size() == 0) fail_now("voice_req_unexpected", voice_idx);
                    else check("voice_idx_seq", voice_idx, idx_q.pop_front());
                end else begin
                    check("voice_idx_hold", voice_idx, e_idx);
                end
                if (e_wait == 0) begin
                    voice_ack    = 1'b1;
                    voice_sample = cur_s[e_idx];
                    e_in = 0;
                end else begin
                    e_wait--;
                end
            end else begin
                e_in = 0;
                if ($urandom_range(0, 3) == 0) voice_ack = 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard on mix_valid and overrun, checks hold and busy.
    initial begin : monitor
        mix_exp_t e;
        bit       exp_ovr;
        int       exp_cnt;
        bit       busy_exp;
        forever begin
            @(negedge clk);
            if (!rst) begin
                exp_ovr = (ovr_cyc_q.size() > 0) && (ovr_cyc_q[0] == cyc);
                exp_cnt = 0;
                if (exp_ovr) begin
                    void'(ovr_cyc_q.pop_front());
                    exp_cnt = ovr_cnt_q.pop_front();
                end
                if (overrun || exp_ovr) begin
                    check("overrun", overrun, exp_ovr);
                    if (exp_ovr) check("overrun_count", overrun_count, exp_cnt);
                end
                if (mix_valid) begin
                    if (mix_q.size() == 0) begin
                        fail_now("mix_valid_unexpected", mix_out);
                        last_mix = mix_out;
                    end else begin
                        e = mix_q.pop_front();
                        check("mix_cycle", cyc, e.cyc);
                        check("mix_out", mix_out, e.val);
                        last_mix = e.val;
                    end
                end else begin
                    check("mix_hold", mix_out, last_mix);
                end
                busy_exp = (cyc > start_cyc && cyc <= done_cyc) || (prev_done != 0 && cyc == prev_done);
                check("busy", busy, busy_exp);
            end
        end
    end

    initial begin : stim
        int k;
        bit seen;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_voice_req", voice_req, 0);
        check("rst_voice_idx", voice_idx, 0);
        check("rst_mix_out", mix_out, 0);
        check("rst_mix_valid", mix_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_overrun_count", overrun_count, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // All voices disabled: mix of zero after NV scan cycles, no requests.
        for (int i = 0; i < NV; i++) begin
            nxt_s[i] = SW'(i + 1);
            nxt_d[i] = 0;
        end
        do_tick(8'h00);
        drain();

        // All voices, zero-wait engine, samples idx+1 -> 36.
        do_tick(8'hFF);
        drain();

        // Voices 0 and 2, 3-cycle ack delay, sum crosses the positive limit.
        for (int i = 0; i < NV; i++) begin
            nxt_s[i] = '0;
            nxt_d[i] = 3;
        end
        nxt_s[0] = 24'h7FFFFF;
        nxt_s[2] = 24'h000001;
        do_tick(8'h05);
        drain();

        // Tick dropped mid-frame, then a tick coincident with DONE.
        rand_voices(0);
        do_tick(8'hFF);
        repeat (3) begin @(posedge clk); #1; end
        do_tick(8'hFF);
        k = 0;
        while (cyc < done_cyc && k < 100) begin @(posedge clk); #1; k++; end
        rand_voices(2);
        do_tick(NV'($urandom));
        drain();
        check("overrun_count_kept", overrun_count, ovr_model);

        // Reset while requesting voice 3.
        for (int i = 0; i < NV; i++) begin
            nxt_s[i] = SW'($urandom);
            nxt_d[i] = 5;
        end
        do_tick(8'hFF);
        k = 0;
        while (!(voice_req && voice_idx == 3) && k < 100) begin @(posedge clk); #1; k++; end
        if (k >= 100) fail_now("wait_idx3_timeout", voice_idx);
        rst = 1'b1;
        mix_q.delete();
        idx_q.delete();
        ovr_cyc_q.delete();
        ovr_cnt_q.delete();
        ovr_model = 0;
        last_mix  = '0;
        start_cyc = 0;
        done_cyc  = 0;
        prev_done = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_voice_req", voice_req, 0);
        check("abort_voice_idx", voice_idx, 0);
        check("abort_mix_out", mix_out, 0);
        check("abort_mix_valid", mix_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_overrun_count", overrun_count, 0);
        seen = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (mix_valid) seen = 1;
        end
        check("abort_no_mix_valid", seen, 0);

        // Clean frame after the abort.
        rand_voices(2);
        do_tick(8'hFF);
        drain();

        // Random frames with random gaps; some ticks land mid-frame or on DONE.
        repeat (40) begin
            rand_voices(3);
            repeat ($urandom_range(0, 45)) begin @(posedge clk); #1; end
            do_tick(NV'($urandom));
        end
        drain();
        repeat (3) begin @(posedge clk); #1; end

        check("idx_queue_empty", idx_q.size(), 0);
        check("ovr_queue_empty", ovr_cyc_q.size(), 0);
        check("mix_queue_empty", mix_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/voice_scheduler.md
VOICE_SCHEDULER -- requirements
Module: voice_scheduler

Interface
REQ-001 Parameter NUM_VOICES, default 8: number of voices time-shared on one voice engine per sample frame; SHALL be >= 2.
REQ-002 Parameter SAMPLE_WIDTH, default 24: signed two's-complement width of voice samples and of the mix output.
REQ-003 Port clk  in  1  system clock; reset is rst, synchronous, active-high.
REQ-004 Port rst  in  1  synchronous active-high reset.
REQ-005 Port sample_tick  in  1  one-cycle frame-start strobe from the sample-rate enable generator.
REQ-006 Port voice_enable  in  NUM_VOICES  per-voice enable mask; bit i enables voice i.
REQ-007 Port voice_req  out  1  request to the shared voice engine.
REQ-008 Port voice_idx  out  $clog2(NUM_VOICES)  index of the voice being requested.
REQ-009 Port voice_ack  in  1  engine acknowledge; voice_sample is valid in the same cycle.
REQ-010 Port voice_sample  in  SAMPLE_WIDTH  signed engine output for voice_idx.
REQ-011 Port mix_out  out  SAMPLE_WIDTH  signed mixed sample of the last completed frame.
REQ-012 Port mix_valid  out  1  one-cycle strobe marking a new mix_out.
REQ-013 Port busy  out  1  high whenever the state is not IDLE.
REQ-014 Port overrun  out  1  one-cycle pulse when a sample_tick is dropped.
REQ-015 Port overrun_count  out  16  count of dropped ticks; saturates at 0xFFFF.

Function
REQ-016 FSM states SHALL be IDLE, SCAN, REQ and DONE.
REQ-017 IDLE: on sample_tick, latch voice_enable into an internal mask, clear the accumulator, set idx=0, go to SCAN; otherwise stay in IDLE.
REQ-018 SCAN (one cycle per index): mask[idx]=1 -> REQ; else idx==NUM_VOICES-1 -> DONE; else idx+1, stay in SCAN.
REQ-019 REQ: assert voice_req with voice_idx=idx, held stable until a cycle with voice_ack=1.
REQ-020 On ack: add sign-extended voice_sample to the accumulator, deassert voice_req next cycle, then go to DONE if idx==NUM_VOICES-1, else increment idx and go to SCAN.
REQ-021 voice_ack while voice_req=0 SHALL be ignored.
REQ-022 Accumulator width SHALL be SAMPLE_WIDTH+$clog2(NUM_VOICES); no overflow is possible within a frame.
REQ-023 DONE lasts exactly one cycle, with mix_valid=1 and mix_out holding the reduced accumulator in that same cycle.
REQ-024 mix_out SHALL hold its value until the next DONE.
REQ-025 From DONE, the next state is SCAN if sample_tick=1 (new frame latched as in IDLE, no overrun); otherwise it is IDLE.
REQ-026 sample_tick in SCAN or REQ SHALL be dropped: overrun=1 next cycle and overrun_count+1 (saturating); the current frame continues unaffected.
REQ-027 voice_enable changes mid-frame SHALL have no effect until the next latch.
REQ-028 Timing with all voices disabled: tick at cycle T -> mix_valid at T+1+NUM_VOICES with mix_out=0.
REQ-029 Timing with all voices enabled and zero-wait ack: tick at T -> mix_valid at T+1+2*NUM_VOICES.

Reset
REQ-030 While rst=1, the block SHALL be forced to: state IDLE, idx 0, accumulator 0, voice_req 0, voice_idx 0, mix_out 0, mix_valid 0, busy 0, overrun 0, overrun_count 0.
REQ-031 rst asserted mid-frame SHALL abandon the frame with no mix_valid, and drop voice_req in the cycle after rst is sampled.

Configuration
REQ-032 Macro VOICE_SCHED_SATURATE_EN defined: the accumulator is clipped to the signed SAMPLE_WIDTH range (max 2^(SAMPLE_WIDTH-1)-1, min -2^(SAMPLE_WIDTH-1)) before loading mix_out.
REQ-033 Macro VOICE_SCHED_SATURATE_EN undefined: mix_out is the low SAMPLE_WIDTH bits of the accumulator (two's-complement wrap).

Verification
REQ-034 Defaults; voice_enable=0x00; tick at T -> mix_valid only at T+9, mix_out=0, voice_req never asserted.
REQ-035 voice_enable=0xFF; engine acks in the same cycle as each request with sample=idx+1 -> voice_idx sequence 0..7, mix_valid at T+17, mix_out=36.
REQ-036 voice_enable=0x05; ack delayed 3 cycles per request with samples 0x7FFFFF and 0x000001 -> req/idx held stable during the waits; mix_out=0x7FFFFF with SATURATE_EN, 0x800000 without.
REQ-037 Second tick 4 cycles after the first with 0xFF enabled -> overrun pulse, overrun_count=1, first frame completes normally; tick coincident with DONE -> new frame starts, count unchanged.
REQ-038 rst asserted while voice_req=1 on idx 3 -> voice_req=0 next cycle, no mix_valid, all outputs 0; the next tick runs a clean frame.
